// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding and BCD constants for the serial adder
package bcd_pkg;
  localparam int DW = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit BCD add with decimal adjust and validity flag
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic          cin,
  output logic [DW-1:0] result,
  output logic          cout,
  output logic          err
);
  logic [DW:0] t;
  // binary sum, then add 6 (mod 16) whenever it passes 9; invalid digits follow the same rule
  always_comb begin
    t = {1'b0, x} + {1'b0, y} + {{DW{1'b0}}, cin};
    cout = t > {1'b0, BCD_MAX};
    result = cout ? t[DW-1:0] + BCD_ADJ : t[DW-1:0];
    err = (x > BCD_MAX) | (y > BCD_MAX);
  end
endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial packed-BCD adder, LSB digit first, with start/done handshake
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [4*DIGITS-1:0] sum,
  output logic               carry_out,
  output logic               error
);
  localparam int CW = $clog2(DIGITS) + 1;
  state_t state_q, state_d;
  logic [4*DIGITS-1:0] op_a_q, op_a_d, op_b_q, op_b_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cout_q, cout_d, err_q, err_d;
  logic [DW-1:0] dx, dy, dr;
  logic dc, de, last;
  // one shared digit adder, fed by the counter-indexed operand digit
  assign dx = op_a_q[DW*int'(cnt_q) +: DW];
  assign dy = op_b_q[DW*int'(cnt_q) +: DW];
  assign last = cnt_q == CW'(DIGITS - 1);
  bcd_digit_add u_dig (.x(dx), .y(dy), .cin(carry_q), .result(dr), .cout(dc), .err(de));
  // next-state: latch operands on start, ripple one digit per ADD cycle, single DONE cycle
  always_comb begin
    state_d = state_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    carry_d = carry_q;
    cout_d = cout_q;
    err_d = err_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        op_a_d = a;
        op_b_d = b;
        sum_d = '0;
        cnt_d = '0;
        carry_d = 1'b0;
        cout_d = 1'b0;
        err_d = 1'b0;
        state_d = S_ADD;
      end
    end else if (state_q == S_ADD) begin
      sum_d[DW*int'(cnt_q) +: DW] = dr;
      carry_d = dc;
      err_d = err_q | de;
      cnt_d = last ? '0 : cnt_q + 1'b1;
      cout_d = last ? dc : cout_q;
      state_d = last ? S_DONE : S_ADD;
    end else begin
      state_d = S_IDLE;
    end
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_a_q <= '0;
      op_b_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
      err_q <= err_d;
    end
  end
  assign ready = state_q == S_IDLE;
  assign busy = state_q == S_ADD;
  assign done = state_q == S_DONE;
  assign sum = sum_q;
  assign carry_out = cout_q;
  assign error = err_q;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: directed vectors with a queue scoreboard checked on each done pulse
module tb_bcd_serial_adder;
  localparam int DIGITS = 4;
  logic clk = 0, rst = 1, start = 0;
  logic [15:0] a = 0, b = 0, sum;
  logic ready, busy, done, carry_out, error;
  typedef struct {
    logic [15:0] sum;
    logic c;
    logic e;
    int cyc;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, cyc = 0, acc_cyc = 0, prev_acc = 0;
  logic prev_done = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done),
    .sum(sum), .carry_out(carry_out), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      chk("done_single_cycle", 32'(prev_done), 0);
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.sum));
        chk("carry_out", 32'(carry_out), 32'(e.c));
        chk("error", 32'(error), 32'(e.e));
        chk("done_latency", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_done = done;
  end

  // called at a negedge; holds start until accepted, optionally leaves it high
  task automatic issue(input logic [15:0] xa, xb, es, input logic ec, ee, input bit hold, input bit push);
    int n;
    exp_t e;
    a = xa;
    b = xb;
    start = 1;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
    prev_acc = acc_cyc;
    acc_cyc = cyc;
    e.sum = es;
    e.c = ec;
    e.e = ee;
    e.cyc = cyc + DIGITS + 1;
    if (push) q.push_back(e);
    @(negedge clk);
    if (!hold) start = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || !ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || !ready) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #12;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(carry_out), 0);
    chk("rst_err", 32'(error), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    issue(16'h1234, 16'h5678, 16'h6912, 0, 0, 0, 1);
    chk("busy_in_add", 32'(busy), 1);
    chk("ready_in_add", 32'(ready), 0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("sum_hold", 32'(sum), 32'h6912);
    issue(16'h9999, 16'h0001, 16'h0000, 1, 0, 0, 1);
    wait_idle();
    issue(16'h00A5, 16'h0003, 16'h0108, 0, 1, 0, 1);
    wait_idle();
    issue(16'h4444, 16'h5555, 16'h9999, 0, 0, 0, 1);
    a = 16'h1111;
    b = 16'h8888;
    wait_idle();
    issue(16'h0001, 16'h0002, 16'h0003, 0, 0, 1, 1);
    issue(16'h0500, 16'h0500, 16'h1000, 0, 0, 0, 1);
    chk("b2b_interval", 32'(acc_cyc - prev_acc), DIGITS + 2);
    wait_idle();
    issue(16'h1111, 16'h2222, 16'h3333, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("abort_ready", 32'(ready), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_cout", 32'(carry_out), 0);
    @(negedge clk);
    rst = 0;
    issue(16'h0005, 16'h0005, 16'h0010, 0, 0, 0, 1);
    wait_idle();
    repeat (DIGITS + 3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
